// File: rtl/skid_pipeline.sv
// Chain of STAGES full-throughput skid slices between valid/ready ports, with flush and occupancy.
// Optional SKID_PIPELINE_STALL_CNT_EN adds a saturating downstream stall counter (stall_cnt).
module skid_pipeline #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int OCC_W  = $clog2(2*STAGES+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occupancy
`ifdef SKID_PIPELINE_STALL_CNT_EN
    ,
    output logic [31:0]      stall_cnt
`endif
);

    logic [STAGES-1:0] w_main_v;
    logic [STAGES-1:0] w_skid_v;
    logic [WIDTH-1:0]  w_main_d [STAGES];
    logic              w_in_fire;
    logic              w_out_fire;
    logic [OCC_W-1:0]  r_occ;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             r_main_v;
        logic             r_skid_v;
        logic [WIDTH-1:0] r_main_d;
        logic [WIDTH-1:0] r_skid_d;
        logic             w_up_valid;
        logic             w_up_ready;
        logic             w_up_fire;
        logic             w_down_ready;
        logic [WIDTH-1:0] w_up_data;

        if (k == 0) begin : g_first
            assign w_up_valid = in_valid;
            assign w_up_data  = in_data;
            // Only the entry slice sees flush; inner transfers are wiped on the same edge anyway.
            assign w_up_ready = !r_skid_v && !flush;
        end else begin : g_inner
            assign w_up_valid = w_main_v[k-1];
            assign w_up_data  = w_main_d[k-1];
            assign w_up_ready = !r_skid_v;
        end

        if (k == STAGES-1) begin : g_last
            assign w_down_ready = out_ready;
        end else begin : g_link
            assign w_down_ready = !w_skid_v[k+1];
        end

        assign w_up_fire   = w_up_valid && w_up_ready;
        assign w_main_v[k] = r_main_v;
        assign w_skid_v[k] = r_skid_v;
        assign w_main_d[k] = r_main_d;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_main_v <= 1'b0;
                r_skid_v <= 1'b0;
                r_main_d <= '0;
                r_skid_d <= '0;
            end else begin
                if (!r_main_v || w_down_ready) begin
                    if (r_skid_v) begin
                        r_main_v <= 1'b1;
                        r_main_d <= r_skid_d;
                        r_skid_v <= 1'b0;
                    end else begin
                        r_main_v <= w_up_fire;
                        if (w_up_fire) begin
                            r_main_d <= w_up_data;
                        end
                    end
                end else if (w_up_fire) begin
                    r_skid_d <= w_up_data;
                    r_skid_v <= 1'b1;
                end
                if (flush) begin
                    r_main_v <= 1'b0;
                    r_skid_v <= 1'b0;
                end
            end
        end
    end

    assign in_ready   = !w_skid_v[0] && !flush;
    assign out_valid  = w_main_v[STAGES-1];
    assign out_data   = w_main_d[STAGES-1];
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ <= '0;
        end else if (flush) begin
            r_occ <= '0;
        end else begin
            r_occ <= r_occ + OCC_W'(w_in_fire) - OCC_W'(w_out_fire);
        end
    end

    assign occupancy = r_occ;

`ifdef SKID_PIPELINE_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (flush) begin
            r_stall_cnt <= '0;
        end else if (out_valid && !out_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_skid_pipeline.sv
// Directed bench for skid_pipeline with a queue-based reference model checked every cycle.
module tb_skid_pipeline;
    localparam int WIDTH  = 8;
    localparam int STAGES = 2;
    localparam int OCC_W  = $clog2(2*STAGES+1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic [OCC_W-1:0] occupancy;
`ifdef SKID_PIPELINE_STALL_CNT_EN
    logic [31:0]      stall_cnt;
`endif

    skid_pipeline #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
`ifdef SKID_PIPELINE_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO of accepted beats, each tagged with the earliest cycle it may show.
    typedef struct {
        logic [WIDTH-1:0] data;
        int               vis;
    } beat_t;

    beat_t            q[$];
    int               cyc = 0;
    logic             s_in = 1'b0;
    logic             s_out = 1'b0;
    logic             s_fl = 1'b0;
    logic [WIDTH-1:0] s_d = '0;
    logic             exp_v;

    always @(negedge clk) begin
        if (!rst) begin
            exp_v = (q.size() > 0) && (q[0].vis <= cyc);
            check("model_out_valid", {31'd0, out_valid}, {31'd0, exp_v});
            if (exp_v) check("model_out_data", {24'd0, out_data}, {24'd0, q[0].data});
            check("model_occupancy", {29'd0, occupancy}, q.size());
            if (flush || q.size() == 2*STAGES)
                check("model_in_ready_low", {31'd0, in_ready}, 32'd0);
            else if (q.size() == 0)
                check("model_in_ready_high", {31'd0, in_ready}, 32'd1);
            s_in  = in_valid && in_ready;
            s_out = exp_v && out_ready;
            s_fl  = flush;
            s_d   = in_data;
        end else begin
            s_in  = 1'b0;
            s_out = 1'b0;
            s_fl  = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            cyc++;
            if (s_out) void'(q.pop_front());
            if (s_in) q.push_back('{data: s_d, vis: cyc + STAGES - 1});
            if (s_fl) q.delete();
            s_in  = 1'b0;
            s_out = 1'b0;
            s_fl  = 1'b0;
        end
    end

    always @(posedge rst) begin
        q.delete();
        s_in  = 1'b0;
        s_out = 1'b0;
        s_fl  = 1'b0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    logic [WIDTH-1:0] stream_d [4];

    initial begin
        stream_d[0] = 8'h55; stream_d[1] = 8'hAA; stream_d[2] = 8'hFF; stream_d[3] = 8'h3C;

        // Reset and release
        repeat (3) @(posedge clk);
        mid();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'h00);
        check("rst_occupancy", {29'd0, occupancy}, 32'd0);
        tick();
        rst = 1'b0;
        mid();
        check("release_in_ready", {31'd0, in_ready}, 32'd1);

        // Single beat latency
        tick();
        in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        mid();
        check("single_not_yet", {31'd0, out_valid}, 32'd0);
        tick();
        mid();
        check("single_valid", {31'd0, out_valid}, 32'd1);
        check("single_data", {24'd0, out_data}, 32'hA5);
        tick();
        mid();
        check("single_one_cycle", {31'd0, out_valid}, 32'd0);

        // Full backpressure
        tick();
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_data = WIDTH'(i);
            mid();
            check("bp_accept", {31'd0, in_ready}, 32'd1);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            mid();
            if (i == 1) begin
                check("bp_full_occ", {29'd0, occupancy}, 32'd4);
                check("bp_full_in_ready", {31'd0, in_ready}, 32'd0);
            end
            check("bp_drain_valid", {31'd0, out_valid}, 32'd1);
            check("bp_drain_data", {24'd0, out_data}, i);
            tick();
        end
        mid();
        check("bp_empty_occ", {29'd0, occupancy}, 32'd0);

        // Streaming
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = stream_d[i];
            mid();
            if (i == 2) begin
                check("stream_occ", {29'd0, occupancy}, 32'd2);
                check("stream_first", {24'd0, out_data}, 32'h55);
            end
            if (i == 3) check("stream_second", {24'd0, out_data}, 32'hAA);
            tick();
        end
        in_valid = 1'b0;
        repeat (4) tick();

        // Flush
        out_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1; in_data = WIDTH'(8'h11 * i);
            tick();
        end
        in_valid = 1'b0;
        flush = 1'b1;
        mid();
        check("flush_in_ready", {31'd0, in_ready}, 32'd0);
        check("flush_pre_occ", {29'd0, occupancy}, 32'd3);
        tick();
        flush = 1'b0;
        mid();
        check("flush_occ", {29'd0, occupancy}, 32'd0);
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        tick();
        in_valid = 1'b1; in_data = 8'h7E; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        mid();
        check("post_flush_valid", {31'd0, out_valid}, 32'd1);
        check("post_flush_data", {24'd0, out_data}, 32'h7E);
        tick();

        // Asynchronous reset mid-stream
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 8'hC0 + WIDTH'(i);
            tick();
        end
        check("arst_pre_valid", {31'd0, out_valid}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_occ", {29'd0, occupancy}, 32'd0);
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        mid();
        check("arst_release_ready", {31'd0, in_ready}, 32'd1);

`ifdef SKID_PIPELINE_STALL_CNT_EN
        tick();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h99;
        tick();
        in_valid = 1'b0;
        tick();
        repeat (5) tick();
        mid();
        check("stall_cnt_5", stall_cnt, 32'd5);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        mid();
        check("stall_cnt_flush", stall_cnt, 32'd0);
`endif

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
